// File: rtl/hex_keypad_pkg.sv
// hex_keypad_pkg: shared types, keymap and row-priority helper for the keypad scanner.
package hex_keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} kp_state_t;

    typedef struct packed {
        logic       any;
        logic [1:0] idx;
    } prio_t;

    // Indexed [row][col]
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    // Lowest active-low row index wins
    function automatic prio_t row_prio(input logic [3:0] r);
        prio_t p;
        p.any = ~&r;
        p.idx = ~r[0] ? 2'd0 : ~r[1] ? 2'd1 : ~r[2] ? 2'd2 : 2'd3;
        return p;
    endfunction

endpackage

// File: rtl/hex_keypad_scanner_sync.sv
// sync_2ff: two-flop synchroniser, resets to all-ones (idle pulled-up rows).
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end

endmodule

// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner: scans a 4x4 active-low keypad, debounces press/release, reports hex key.
module hex_keypad_scanner
    import hex_keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50_000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    kp_state_t     state, state_n;
    logic [3:0]    rows_s;
    logic [DW-1:0] dwell;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [1:0]    col_idx, lat_row, lat_col;
    logic          sample, rotate, latch, accept;
    prio_t         prio;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (rows),
        .q    (rows_s)
    );

    assign sample  = dwell == DW'(SCAN_DIV - 1);
    assign cnt_inc = cnt + 1'b1;
    assign prio    = row_prio(rows_s);

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= SCAN;
        else       state <= state_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rotate  = 1'b0;
        latch   = 1'b0;
        accept  = 1'b0;
        if (sample)
            case (state)
                SCAN:
                    if (!prio.any) rotate = 1'b1;
                    else begin
                        latch = 1'b1;
                        if (DEBOUNCE_CNT == 1) begin
                            accept  = 1'b1;
                            state_n = PRESSED;
                            cnt_n   = '0;
                        end else begin
                            state_n = DEBOUNCE;
                            cnt_n   = CW'(1);
                        end
                    end
                DEBOUNCE:
                    if (prio.any && prio.idx == lat_row) begin
                        if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
                            accept  = 1'b1;
                            state_n = PRESSED;
                            cnt_n   = '0;
                        end else cnt_n = cnt_inc;
                    end else begin
                        state_n = SCAN;
                        cnt_n   = '0;
                        rotate  = 1'b1;
                    end
                PRESSED:
                    if (rows_s[lat_row]) begin
                        if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
                            state_n = SCAN;
                            cnt_n   = '0;
                            rotate  = 1'b1;
                        end else cnt_n = cnt_inc;
                    end else cnt_n = '0;
                default: state_n = SCAN;
            endcase
    end

    always_comb begin
        cols     = ~(4'b0001 << col_idx);
        key_held = state == PRESSED;
    end

    // Acceptance straight from SCAN uses the live indices, otherwise the latched ones
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            dwell     <= '0;
            cnt       <= '0;
            col_idx   <= 2'd0;
            lat_row   <= 2'd0;
            lat_col   <= 2'd0;
            key_value <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            dwell     <= sample ? '0 : dwell + 1'b1;
            cnt       <= cnt_n;
            col_idx   <= col_idx + {1'b0, rotate};
            lat_row   <= latch ? prio.idx : lat_row;
            lat_col   <= latch ? col_idx : lat_col;
            key_value <= accept ? KEYMAP[latch ? prio.idx : lat_row][latch ? col_idx : lat_col] : key_value;
            key_valid <= accept;
        end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// tb_hex_keypad_scanner: directed scenarios against a keypad model, SCAN_DIV=4, DEBOUNCE_CNT=3.
module tb_hex_keypad_scanner;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows, cols, key_value;
    logic       key_valid, key_held;
    logic [3:0] pressed [4];
    int         tests = 0;
    int         fails = 0;

    localparam logic [3:0] EXP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    always #5 clock = ~clock;

    // pressed[r][c] pulls row r low while column c is driven low
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) rows[r] = ~|(pressed[r] & ~cols);
    end

    hex_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .key_value(key_value),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    task automatic release_all();
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    endtask

    task automatic wait_cols(input logic [3:0] c, output bit ok);
        logic [3:0] prev;
        prev = cols;
        ok   = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clock);
            ok   = (cols == c) && (prev != c);
            prev = cols;
        end
    endtask

    task automatic wait_valid(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clock);
            ok = key_valid;
        end
    endtask

    task automatic wait_release(output bit ok, output int extra);
        ok    = 1'b0;
        extra = 0;
        for (int i = 0; i < 24 && !ok; i++) begin
            @(negedge clock);
            extra += int'(key_valid);
            ok = !key_held;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        tests++;
        if ({cols, key_value, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: cols=%b value=%h valid=%b held=%b, want 1110 0 0 0", cols, key_value, key_valid, key_held);
        end
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            logic [3:0] exp_cols;
            if (k > 0) @(negedge clock);
            exp_cols = ~(4'b0001 << ((k / 4) % 4));
            tests++;
            if (cols !== exp_cols || key_valid !== 1'b0 || key_value !== 4'h0) begin
                fails++;
                $display("FAIL idle_scan k=%0d: cols=%b valid=%b value=%h, want %b 0 0", k, cols, key_valid, key_value, exp_cols);
            end
        end
    endtask

    task automatic test_single_key();
        int pulses = 0;
        int extra;
        logic [3:0] seen = 4'hx;
        bit ok;
        pressed[1][2] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (key_valid) begin
                pulses++;
                seen = key_value;
            end
        end
        tests++;
        if (pulses !== 1 || seen !== 4'h6 || key_held !== 1'b1 || cols !== 4'b1011) begin
            fails++;
            $display("FAIL single_key: pulses=%0d value=%h held=%b cols=%b, want 1 6 1 1011", pulses, seen, key_held, cols);
        end
        release_all();
        wait_release(ok, extra);
        tests++;
        if (!ok || extra != 0) begin
            fails++;
            $display("FAIL single_release: released=%b extra_pulses=%0d, want 1 0", ok, extra);
        end
        tests++;
        if (cols !== 4'b0111) begin
            fails++;
            $display("FAIL resume_rotate: cols=%b, want 0111", cols);
        end
        wait_cols(4'b1110, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL resume_scan: cols stuck at %b, want rotation to 1110", cols);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        int extra;
        bit ok;
        wait_cols(4'b1101, ok);
        pressed[3][1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            pulses += int'(key_valid);
        end
        release_all();
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            pulses += int'(key_valid);
        end
        tests++;
        if (!ok || pulses != 0 || key_value !== 4'h6 || key_held !== 1'b0) begin
            fails++;
            $display("FAIL bounce: aligned=%b pulses=%0d value=%h held=%b, want 1 0 6 0", ok, pulses, key_value, key_held);
        end
        wait_cols(4'b1101, ok);
        pressed[3][1] = 1'b1;
        repeat (11) @(negedge clock);
        tests++;
        if (!ok || key_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: aligned=%b valid=%b, want 1 0", ok, key_valid);
        end
        @(negedge clock);
        tests++;
        if (key_valid !== 1'b1 || key_value !== 4'hF) begin
            fails++;
            $display("FAIL latency_pulse: valid=%b value=%h, want 1 F", key_valid, key_value);
        end
        @(negedge clock);
        tests++;
        if (key_valid !== 1'b0 || key_held !== 1'b1 || key_value !== 4'hF || cols !== 4'b1101) begin
            fails++;
            $display("FAIL pulse_width: valid=%b held=%b value=%h cols=%b, want 0 1 F 1101", key_valid, key_held, key_value, cols);
        end
        release_all();
        wait_release(ok, extra);
        tests++;
        if (!ok || extra != 0) begin
            fails++;
            $display("FAIL bounce_release: released=%b extra_pulses=%0d, want 1 0", ok, extra);
        end
    endtask

    task automatic test_two_rows();
        int extra;
        bit ok;
        pressed[0][3] = 1'b1;
        pressed[2][3] = 1'b1;
        wait_valid(60, ok);
        tests++;
        if (!ok || key_value !== 4'hA) begin
            fails++;
            $display("FAIL two_rows_prio: seen=%b value=%h, want 1 A", ok, key_value);
        end
        @(negedge clock);
        pressed[0][3] = 1'b0;
        wait_release(ok, extra);
        tests++;
        if (!ok || extra != 0) begin
            fails++;
            $display("FAIL two_rows_release: released=%b extra_pulses=%0d, want 1 0", ok, extra);
        end
        wait_valid(60, ok);
        tests++;
        if (!ok || key_value !== 4'hC) begin
            fails++;
            $display("FAIL two_rows_next: seen=%b value=%h, want 1 C", ok, key_value);
        end
        release_all();
        wait_release(ok, extra);
        tests++;
        if (!ok || extra != 0) begin
            fails++;
            $display("FAIL two_rows_final: released=%b extra_pulses=%0d, want 1 0", ok, extra);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        bit ok;
        wait_cols(4'b1101, ok);
        pressed[2][1] = 1'b1;
        repeat (6) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        tests++;
        if (!ok || {cols, key_value, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_debounce: aligned=%b cols=%b value=%h valid=%b held=%b, want 1 1110 0 0 0", ok, cols, key_value, key_valid, key_held);
        end
        release_all();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            pulses += int'(key_valid);
        end
        tests++;
        if (pulses != 0 || key_value !== 4'h0) begin
            fails++;
            $display("FAIL reset_debounce_after: pulses=%0d value=%h, want 0 0", pulses, key_value);
        end
        wait_cols(4'b1101, ok);
        pressed[2][1] = 1'b1;
        repeat (13) @(negedge clock);
        tests++;
        if (!ok || key_held !== 1'b1 || key_value !== 4'h8) begin
            fails++;
            $display("FAIL pre_reset_pressed: aligned=%b held=%b value=%h, want 1 1 8", ok, key_held, key_value);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({cols, key_value, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_pressed: cols=%b value=%h valid=%b held=%b, want 1110 0 0 0", cols, key_value, key_valid, key_held);
        end
        release_all();
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            pulses += int'(key_valid);
        end
        tests++;
        if (pulses != 0 || key_value !== 4'h0 || key_held !== 1'b0) begin
            fails++;
            $display("FAIL reset_pressed_after: pulses=%0d value=%h held=%b, want 0 0 0", pulses, key_value, key_held);
        end
    endtask

    task automatic test_all_keys();
        int extra;
        bit ok;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                pressed[r][c] = 1'b1;
                wait_valid(80, ok);
                tests++;
                if (!ok || key_value !== EXP[r][c]) begin
                    fails++;
                    $display("FAIL key_r%0d_c%0d: seen=%b value=%h, want 1 %h", r, c, ok, key_value, EXP[r][c]);
                end
                release_all();
                wait_release(ok, extra);
                tests++;
                if (!ok || extra != 0) begin
                    fails++;
                    $display("FAIL key_r%0d_c%0d_release: released=%b extra_pulses=%0d, want 1 0", r, c, ok, extra);
                end
            end
    endtask

    initial begin
        release_all();
        test_reset();
        test_single_key();
        test_bounce();
        test_two_rows();
        test_reset_mid();
        test_all_keys();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
